// File: rtl/sdes_key_schedule.sv
// S-DES subkey generator: P10, LS-1, P8, LS-2, P8 over five clock edges.
// Optional macro SDES_KEYSCHED_DECRYPT_EN swaps subkey order for decryption.
module sdes_key_schedule (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [9:0] key,
    input  logic       decrypt,
    output logic       busy,
    output logic       valid,
    output logic [7:0] key_1,
    output logic [7:0] key_2
);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT1,
        GEN_K1,
        SHIFT2,
        GEN_K2
    } state_t;

    state_t     state;
    logic [9:0] work;
    logic [7:0] k1_reg;
    logic [7:0] k2;
    logic       mode;

    // Bit 9 is k1 / w1, bit 0 is k10 / w10.
    function automatic logic [9:0] p10(input logic [9:0] k);
        return {k[7], k[5], k[8], k[3], k[6], k[0], k[9], k[1], k[2], k[4]};
    endfunction

    function automatic logic [7:0] p8(input logic [9:0] w);
        return {w[4], w[7], w[3], w[6], w[2], w[5], w[0], w[1]};
    endfunction

    function automatic logic [9:0] rot1(input logic [9:0] w);
        return {w[8:5], w[9], w[3:0], w[4]};
    endfunction

    function automatic logic [9:0] rot2(input logic [9:0] w);
        return {w[7:5], w[9:8], w[2:0], w[4:3]};
    endfunction

    assign k2 = p8(work);

`ifdef SDES_KEYSCHED_DECRYPT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            mode <= 1'b0;
        end else if (state == IDLE && start) begin
            mode <= decrypt;
        end
    end
`else
    logic unused_decrypt;
    assign unused_decrypt = decrypt;
    assign mode = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            work   <= 10'd0;
            k1_reg <= 8'd0;
            busy   <= 1'b0;
            valid  <= 1'b0;
            key_1  <= 8'd0;
            key_2  <= 8'd0;
        end else begin
            valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        work  <= p10(key);
                        busy  <= 1'b1;
                        state <= SHIFT1;
                    end
                end
                SHIFT1: begin
                    work  <= rot1(work);
                    state <= GEN_K1;
                end
                GEN_K1: begin
                    k1_reg <= p8(work);
                    state  <= SHIFT2;
                end
                SHIFT2: begin
                    work  <= rot2(work);
                    state <= GEN_K2;
                end
                GEN_K2: begin
                    key_1 <= mode ? k2 : k1_reg;
                    key_2 <= mode ? k1_reg : k2;
                    valid <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
